// File: rtl/smvm_pkg.sv
`default_nettype none
// smvm_pkg: shared state encoding, saturation limits and FIFO entry width for the SMVM result collector.
package smvm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Saturation window is the signed 20-bit range.
  localparam int SAT_MAX = 524287;
  localparam int SAT_MIN = -524288;

  localparam int ROW_W      = 8;
  localparam int DEFAULT_HW = 14;
  localparam int ENTRY_W    = ROW_W + 1 + 2 * DEFAULT_HW;

  // Entry layout: {row, last, data}.
  function automatic int entry_w(input int hw);
    return ROW_W + 1 + 2 * hw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/smvm_collect_fifo.sv
`default_nettype none
// smvm_collect_fifo: first-word-fall-through result FIFO with occupancy count.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module smvm_collect_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/smvm_result_collector.sv
`default_nettype none
// smvm_result_collector: pairs SMVM half-words into row results and queues them for a consumer.
// Optional SMVM_COLLECT_SAT_EN clamps each result to the signed 20-bit range before queueing.
module smvm_result_collector
  import smvm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HW    = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  input  logic [7:0]      cfg_rows,
  input  logic            in_valid,
  input  logic [HW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*HW-1:0] out_data,
  output logic [7:0]      out_row,
  output logic            out_last,
  output logic            done,
  output logic            ovf_err
);

  localparam int DW = 2 * HW;
  localparam int EW = entry_w(HW);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic            hi_phase;
  logic [HW-1:0]   hi_reg;
  logic [7:0]      row_cnt;
  logic [7:0]      rows_cfg;
  logic            zero_done;
  logic            drain_done;

  logic            cfg_take;
  logic            word_take;
  logic            lo_take;
  logic            is_last;
  logic [DW-1:0]   assembled;
  logic [DW-1:0]   sat_data;
  logic [EW-1:0]   head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            pop;
  logic            drop;

  assign cfg_take  = (state == IDLE) && cfg_valid;
  assign word_take = (state == COLLECT) && in_valid;
  assign lo_take   = word_take && !hi_phase;
  assign is_last   = (row_cnt == rows_cfg - 8'd1);
  assign assembled = {hi_reg, in_data};

`ifdef SMVM_COLLECT_SAT_EN
  localparam logic signed [DW-1:0] SAT_HI = DW'(SAT_MAX);
  localparam logic signed [DW-1:0] SAT_LO = DW'(SAT_MIN);

  always_comb begin
    sat_data = assembled;
    if ($signed(assembled) > SAT_HI)      sat_data = SAT_HI;
    else if ($signed(assembled) < SAT_LO) sat_data = SAT_LO;
  end
`else
  assign sat_data = assembled;
`endif

  assign out_valid = (fifo_count != '0);
  assign fifo_full = (fifo_count == CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the push when the consumer frees the head in the same cycle.
  assign drop      = lo_take && fifo_full && !pop;

  smvm_collect_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lo_take),
    .push_data ({row_cnt, is_last, sat_data}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  assign out_data = out_valid ? head[DW-1:0]  : '0;
  assign out_last = out_valid ? head[DW]      : 1'b0;
  assign out_row  = out_valid ? head[EW-1 -: 8] : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      IDLE:    if (cfg_valid && cfg_rows != 8'd0) state_nxt = COLLECT;
      COLLECT: if (lo_take && is_last) state_nxt = DRAIN;
      DRAIN: begin
        if (!out_valid) begin
          state_nxt  = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done = drain_done || zero_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_phase  <= 1'b1;
      hi_reg    <= '0;
      row_cnt   <= 8'd0;
      rows_cfg  <= 8'd0;
      ovf_err   <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= cfg_take && (cfg_rows == 8'd0);
      if (cfg_take) begin
        rows_cfg <= cfg_rows;
        row_cnt  <= 8'd0;
        ovf_err  <= 1'b0;
      end
      if (word_take) begin
        hi_phase <= !hi_phase;
        if (hi_phase) hi_reg <= in_data;
      end
      // Dropped results still consume a row index.
      if (lo_take) row_cnt <= row_cnt + 8'd1;
      if (drop)    ovf_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smvm_result_collector.sv
`default_nettype none
// tb_smvm_result_collector: scoreboard bench with a queue-level reference model of the collector.
module tb_smvm_result_collector;

  localparam int DEPTH = 8;
  localparam int HW    = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [7:0]      cfg_rows = 8'd0;
  logic            in_valid = 1'b0;
  logic [HW-1:0]   in_data = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [2*HW-1:0] out_data;
  logic [7:0]      out_row;
  logic            out_last;
  logic            done;
  logic            ovf_err;

  smvm_result_collector #(.DEPTH(DEPTH), .HW(HW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_rows  (cfg_rows),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .done      (done),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  row;
    logic        last;
    logic [27:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  bit          exp_ovf = 1'b0;
  int          job_rows = 0;
  int          word_idx = 0;
  logic [13:0] hi_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  // Reference value: concatenate halves, optionally clamp as a signed integer.
  function automatic logic [27:0] model_val(input logic [13:0] h, input logic [13:0] l);
    logic signed [27:0] v;
    int iv;
    v  = {h, l};
    iv = v;
`ifdef SMVM_COLLECT_SAT_EN
    if (iv > 524287)  iv = 524287;
    if (iv < -524288) iv = -524288;
`endif
    return iv[27:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        check("done_fifo_empty", exp_q.size(), 0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got row %0d data 0x%0h, want no output", out_row, out_data);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_row",  out_row,  exp_q[0].row);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_zero", {out_data, out_row, out_last}, 0);
      end
    end
  end

  task automatic tick(input bit v, input logic [13:0] d, input bit rdy);
    @(posedge clk); #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic start_job(input int rows);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_rows  = rows[7:0];
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    job_rows  = rows;
    word_idx  = 0;
    exp_ovf   = 1'b0;
    check("ovf_clear_on_cfg", ovf_err, 0);
  endtask

  // Queue size here equals DUT occupancy, so a full queue without ready means a drop.
  task automatic send_word(input logic [13:0] d, input bit rdy);
    exp_t e;
    int   row;
    tick(1'b1, d, rdy);
    if (word_idx % 2 == 0) begin
      hi_word = d;
    end else begin
      row    = word_idx / 2;
      e.row  = row[7:0];
      e.last = (row == job_rows - 1);
      e.data = model_val(hi_word, d);
      if (exp_q.size() >= DEPTH && !rdy) exp_ovf = 1'b1;
      else exp_q.push_back(e);
    end
    word_idx++;
  endtask

  task automatic finish_job();
    int start;
    int k;
    start = done_cnt;
    k = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (done_cnt == start && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt - start, 1);
    check("ovf_err", ovf_err, exp_ovf);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    int rows;
    int rdy_pct;
    logic [13:0] w;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, out_data, out_row, out_last, done, ovf_err}, 0);
    rst_n = 1'b1;

    // Two-row job with ready high, including first-result latency.
    start_job(2);
    send_word(14'h0000, 1'b1);
    send_word(14'h0005, 1'b1);
    @(negedge clk);
    check("latency_before", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_after", out_valid, 1);
    check("first_result", out_data, 28'h0000005);
    send_word(14'h3FFF, 1'b1);
    send_word(14'h3FFE, 1'b1);
    finish_job();

    // Ten rows into an eight-deep FIFO with no consumer: rows 8 and 9 dropped.
    start_job(10);
    for (int i = 0; i < 20; i++) send_word(14'($urandom), 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ovf_set", ovf_err, 1);
    check("kept_rows", exp_q.size(), 8);
    finish_job();

    // Full FIFO with a simultaneous push and pop must not overflow.
    start_job(12);
    for (int i = 0; i < 17; i++) send_word(14'($urandom), 1'b0);
    send_word(14'($urandom), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("ovf_push_pop_full", ovf_err, 0);
    for (int i = 0; i < 6; i++) send_word(14'($urandom), 1'b1);
    finish_job();

    // Asynchronous reset after the high half of row 1.
    start_job(3);
    send_word(14'h0001, 1'b0);
    send_word(14'h0002, 1'b0);
    send_word(14'h0003, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {out_valid, out_data, out_row, out_last, done, ovf_err}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_job(1);
    send_word(14'h0000, 1'b1);
    send_word(14'h0001, 1'b1);
    finish_job();

    // Zero-row job: done on the following cycle only.
    start = done_cnt;
    start_job(0);
    #1;
    check("zero_rows_done", done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("zero_rows_done_count", done_cnt - start, 1);

    // cfg_valid mid-job is ignored.
    start_job(2);
    send_word(14'h0011, 1'b1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_rows  = 8'd5;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    send_word(14'h0022, 1'b1);
    send_word(14'h0033, 1'b1);
    send_word(14'h0044, 1'b1);
    finish_job();

    // Saturation boundary value (clamped or passed through by build).
    start_job(1);
    send_word(14'h0040, 1'b1);
    send_word(14'h0000, 1'b1);
    finish_job();

    // Randomized jobs with gaps and varying consumer pressure.
    for (int j = 0; j < 8; j++) begin
      rows    = $urandom_range(1, 20);
      rdy_pct = (j % 3 == 0) ? 20 : 70;
      start_job(rows);
      for (int i = 0; i < 2 * rows; i++) begin
        while ($urandom_range(0, 99) < 25) begin
          w = 14'($urandom);
          tick(1'b0, w, $urandom_range(0, 99) < rdy_pct);
        end
        w = 14'($urandom);
        send_word(w, $urandom_range(0, 99) < rdy_pct);
      end
      finish_job();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/smvm_result_collector.md
SMVM_RESULT_COLLECTOR -- requirements
Module: smvm_result_collector

Interface
REQ-001 Parameter DEPTH, default 8: result FIFO depth in entries, power of two, range 2..32.
REQ-002 Parameter HW, default 14: half-word width of the incoming stream.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_valid  input  1  one-cycle pulse that starts a job; sampled only in IDLE.
REQ-006 cfg_rows  input  8  number of matrix rows (28-bit results) expected for the job.
REQ-007 in_valid  input  1  half-word strobe from the SMVM output stage; no backpressure is available upstream.
REQ-008 in_data  input  HW  half-word; the high half (bits 27:14) arrives first, then the low half (bits 13:0).
REQ-009 out_valid  output  1  head FIFO entry is valid.
REQ-010 out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both high.
REQ-011 out_data  output  2*HW  assembled row result.
REQ-012 out_row  output  8  row index of out_data, counting from 0.
REQ-013 out_last  output  1  out_data is the final row of the job.
REQ-014 done  output  1  one-cycle pulse when the job completes.
REQ-015 ovf_err  output  1  sticky flag: a result was dropped because the FIFO was full.

Function
REQ-016 FSM states: IDLE, COLLECT, DRAIN.
- IDLE to COLLECT on cfg_valid with cfg_rows>0.
- COLLECT to DRAIN when the cfg_rows-th result is assembled.
- DRAIN to IDLE when the FIFO is empty; done pulses in that same cycle.
REQ-017 cfg_valid with cfg_rows==0 in IDLE shall pulse done on the next cycle and stay in IDLE.
REQ-018 cfg_valid outside IDLE shall be ignored.
REQ-019 in_valid outside COLLECT shall be ignored; the half-toggle and hi register do not change.
REQ-020 In COLLECT, a half-toggle starts at HI.
- An in_valid word with toggle=HI shall be stored in the hi register.
- An in_valid word with toggle=LO shall form {hi, in_data} and push {row_cnt, last, data} into the FIFO.
- Each accepted word flips the toggle.
REQ-021 row_cnt shall increment on every assembled result, including dropped ones; last = (row_cnt == cfg_rows-1).
REQ-022 Latency: the low half accepted in cycle N shall appear on the outputs with out_valid=1 in cycle N+1 if the FIFO was empty.
REQ-023 FIFO shall be first-word-fall-through; out_data, out_row and out_last shall be held stable while out_valid=1 and out_ready=0.
REQ-024 Push and pop in the same cycle on a full FIFO shall both succeed, and the count is unchanged.
REQ-025 Push on a full FIFO without a pop shall drop the result and set ovf_err; row_cnt still advances.
REQ-026 ovf_err shall clear only on reset or on an accepted cfg_valid.
REQ-027 Pointers shall wrap modulo DEPTH; full and empty shall be distinguished by an occupancy count of width clog2(DEPTH)+1.
REQ-028 When out_valid=0, out_data, out_row and out_last shall be 0.

Reset
REQ-029 Asynchronous assertion of rst_n, including mid-job, shall give:
- state IDLE, FIFO empty, toggle HI, hi register 0, row_cnt 0;
- out_valid, out_data, out_row, out_last, done and ovf_err all 0.
REQ-030 Partial results and FIFO contents are discarded on reset; no done pulse is produced.

Configuration
REQ-031 Macro SMVM_COLLECT_SAT_EN.
- Defined: the assembled value, as signed 28-bit, shall be clamped to [-524288, 524287] (signed 20-bit range), sign-extended back to 28 bits, before the push.
- Undefined: the value passes through unmodified.

Structure
REQ-032 Shared package smvm_pkg holds:
- the state encoding (IDLE=0, COLLECT=1, DRAIN=2);
- the SAT limits as constants;
- the FIFO entry width constant (8+1+2*HW).
REQ-033 Storage shall be a sub-module smvm_collect_fifo (parameterized DEPTH and width, FWFT, count output); assembly, FSM and saturation remain in the top module.

Verification
REQ-034 cfg_rows=2; words 0x0000,0x0005,0x3FFF,0x3FFE; out_ready=1 -> two outputs:
- 0x0000005, row 0, last 0;
- 0xFFFFFFE, row 1, last 1;
- then done pulses once.
REQ-035 DEPTH=8, cfg_rows=10, out_ready=0, 20 words -> rows 0..7 are kept and rows 8 and 9 are dropped.
- ovf_err=1.
- Raising out_ready then drains rows 0..7 in order, and done pulses after the 8th pop.
REQ-036 FIFO full with out_ready=1 while a low half arrives -> push and pop in the same cycle, count stays 8, ovf_err stays 0.
REQ-037 rst_n asserted after the high half of row 1 -> all outputs 0 immediately.
- A new cfg_rows=1 job with words 0x0000,0x0001 yields 0x0000001, row 0.
REQ-038 cfg_rows=0 -> done on the next cycle; cfg_valid asserted during COLLECT does not alter row_cnt or cfg_rows.
REQ-039 SMVM_COLLECT_SAT_EN defined; words 0x0040,0x0000 (0x0100000) -> 0x007FFFF.
- Undefined -> 0x0100000 unchanged.
